// File: rtl/multi_bit_seq_detector_pkg.sv
// multi_bit_seq_detector_pkg: shared FSM encoding for the serial pattern detector
package multi_bit_seq_detector_pkg;
  typedef enum logic {ST_FILL, ST_RUN} state_e;
endpackage

// File: rtl/seq_det_window_cmp.sv
// seq_det_window_cmp: compares every PW-bit window ending inside the beat against the pattern
module seq_det_window_cmp
  import multi_bit_seq_detector_pkg::*;
#(
  parameter int DW = 2,
  parameter int PW = 7
) (
  input  logic [PW-2:0] hist_i,
  input  logic [DW-1:0] data_i,
  input  logic [PW-1:0] pat_i,
  output logic [DW-1:0] hit_o
);
  logic [PW+DW-2:0] s;
  assign s = {hist_i, data_i};
  for (genvar k = 0; k < DW; k++) begin : g_win
    assign hit_o[k] = s[k+PW-1:k] == pat_i;
  end
endmodule

// File: rtl/multi_bit_seq_detector.sv
// multi_bit_seq_detector: DW-bit-per-beat detector of a programmable PW-bit pattern.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module multi_bit_seq_detector
  import multi_bit_seq_detector_pkg::*;
#(
  parameter int DW    = 2,
  parameter int PW    = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [DW-1:0]    in_data,
  input  logic [PW-1:0]    cfg_pat,
  input  logic             cfg_ovlp,
  output logic             match,
  output logic [DW-1:0]    match_pos,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(PW+1);
  state_e state_q, state_d;
  logic [PW-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d, gap_q, gap_d;
  logic [DW-1:0] pos_q, pos_d, hit;
  logic [PW+DW-2:0] s;
  int g;
  assign s = {hist_q, in_data};
  seq_det_window_cmp #(.DW(DW), .PW(PW)) u_cmp (
    .hist_i(hist_q),
    .data_i(in_data),
    .pat_i (cfg_pat),
    .hit_o (hit)
  );
  // oldest bit first so a reported hit closes the gap for the younger positions
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    gap_d   = gap_q;
    state_d = state_q;
    pos_d   = '0;
    g       = int'(gap_q);
    for (int k = DW-1; k >= 0; k--) begin
      g = (g + 1 > PW) ? PW : g + 1;
      if (hit[k] && (state_q == ST_RUN || int'(fill_q) + DW - k >= PW) && (cfg_ovlp || g >= PW)) begin
        pos_d[k] = 1'b1;
        g        = 0;
      end
    end
    if (clr) begin
      hist_d  = '0;
      fill_d  = '0;
      gap_d   = FW'(PW);
      state_d = ST_FILL;
      pos_d   = '0;
    end else if (in_vld) begin
      hist_d  = s[PW-2:0];
      fill_d  = (int'(fill_q) + DW >= PW) ? FW'(PW) : fill_q + FW'(DW);
      gap_d   = FW'(g);
      state_d = (fill_d == FW'(PW)) ? ST_RUN : state_q;
    end else begin
      pos_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      gap_q   <= FW'(PW);
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      gap_q   <= gap_d;
      pos_q   <= pos_d;
    end
  end
  assign match     = |pos_q;
  assign match_pos = pos_q;
`ifdef SEQ_DET_CNT_EN
  localparam int SW = CNT_W + $clog2(DW+1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum;
  assign sum   = SW'(cnt_q) + SW'($countones(pos_d));
  assign cnt_d = clr ? '0 : (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_bit_seq_detector.sv
// tb_multi_bit_seq_detector: directed vectors with a queued scoreboard for DW=2, PW=7
module tb_multi_bit_seq_detector;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_vld = 1'b0, cfg_ovlp = 1'b1;
  logic [1:0] in_data = '0;
  logic [6:0] cfg_pat = '0;
  logic match;
  logic [1:0] match_pos;
  logic [7:0] match_cnt;
  typedef struct { logic [1:0] pos; logic [7:0] cnt; int id; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, exp_cnt = 0, id = 0;

  multi_bit_seq_detector #(.DW(2), .PW(7), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .cfg_pat(cfg_pat), .cfg_ovlp(cfg_ovlp), .match(match), .match_pos(match_pos),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, n, act, exp);
    end
  endfunction

  task automatic step(input logic v, input logic [1:0] d, input logic c, input logic [1:0] e);
    exp_t x;
    @(negedge clk);
    in_vld = v; in_data = d; clr = c;
    if (c) exp_cnt = 0;
    else if (v) exp_cnt = (exp_cnt + $countones(e) > 255) ? 255 : exp_cnt + $countones(e);
    id++;
    x.pos = e;
    x.id  = id;
`ifdef SEQ_DET_CNT_EN
    x.cnt = 8'(exp_cnt);
`else
    x.cnt = 8'd0;
`endif
    q.push_back(x);
  endtask

  task automatic setup(input logic [6:0] p, input logic o);
    @(negedge clk);
    cfg_pat = p; cfg_ovlp = o;
    clr = 1'b0;
    step(1'b1, 2'b11, 1'b1, 2'b00);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("match_pos", x.id, 32'(match_pos), 32'(x.pos));
        chk("match", x.id, 32'(match), 32'(|x.pos));
        chk("match_cnt", x.id, 32'(match_cnt), 32'(x.cnt));
      end
    end
  end

  initial begin : stim
    #12;
    chk("reset_match", 0, 32'(match), 0);
    chk("reset_pos", 0, 32'(match_pos), 0);
    chk("reset_cnt", 0, 32'(match_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    // basic alignment: pattern ends on the earlier bit
    setup(7'b1011001, 1'b1);
    step(1, 2'b10, 0, 2'b00); step(1, 2'b11, 0, 2'b00);
    step(1, 2'b00, 0, 2'b00); step(1, 2'b10, 0, 2'b10);
    // odd alignment: pattern ends on the later bit
    setup(7'b1011001, 1'b1);
    step(1, 2'b01, 0, 2'b00); step(1, 2'b01, 0, 2'b00);
    step(1, 2'b10, 0, 2'b00); step(1, 2'b01, 0, 2'b01);
    // warm-up gating on an all-zero pattern
    setup(7'b0000000, 1'b1);
    for (int i = 1; i <= 6; i++) step(1, 2'b00, 0, (i >= 4) ? 2'b11 : 2'b00);
    // alternating stream, overlapping then non-overlapping
    setup(7'b1010101, 1'b1);
    for (int i = 1; i <= 10; i++) step(1, 2'b10, 0, (i >= 4) ? 2'b10 : 2'b00);
    setup(7'b1010101, 1'b0);
    for (int i = 1; i <= 13; i++) step(1, 2'b10, 0, (i % 4 == 0) ? 2'b10 : 2'b00);
    // non-overlap gap crossing beat boundaries: hits at bits 7,14,21,28
    setup(7'b0000000, 1'b0);
    for (int i = 1; i <= 14; i++)
      step(1, 2'b00, 0, (i == 4 || i == 11) ? 2'b10 : (i == 7 || i == 14) ? 2'b01 : 2'b00);
    // idle cycle inside the pattern holds history
    setup(7'b1011001, 1'b1);
    step(1, 2'b10, 0, 2'b00); step(1, 2'b11, 0, 2'b00); step(0, 2'b11, 0, 2'b00);
    step(1, 2'b00, 0, 2'b00); step(1, 2'b10, 0, 2'b10);
    // clr together with a beat discards it and the partial pattern
    setup(7'b1011001, 1'b1);
    step(1, 2'b10, 0, 2'b00); step(1, 2'b11, 0, 2'b00); step(1, 2'b00, 0, 2'b00);
    step(1, 2'b10, 1, 2'b00); step(1, 2'b10, 0, 2'b00); step(0, 2'b00, 0, 2'b00);
    // async reset right after a hit clears outputs and restarts warm-up
    setup(7'b1011001, 1'b1);
    step(1, 2'b10, 0, 2'b00); step(1, 2'b11, 0, 2'b00);
    step(1, 2'b00, 0, 2'b00); step(1, 2'b10, 0, 2'b10);
    @(posedge clk);
    #2;
    in_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_mid_pos", id, 32'(match_pos), 0);
    chk("rst_mid_match", id, 32'(match), 0);
    chk("rst_mid_cnt", id, 32'(match_cnt), 0);
    exp_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    step(1, 2'b00, 0, 2'b00); step(1, 2'b10, 0, 2'b00); step(1, 2'b10, 0, 2'b00);
    step(1, 2'b11, 0, 2'b00); step(1, 2'b00, 0, 2'b00); step(1, 2'b10, 0, 2'b10);
    // long all-zero run drives the counter into saturation
    setup(7'b0000000, 1'b1);
    for (int i = 1; i <= 140; i++) step(1, 2'b00, 0, (i >= 4) ? 2'b11 : 2'b00);
    step(0, 2'b00, 0, 2'b00);
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
